// File: rtl/audiodac_pkg.sv
// Shared types and constants for the audio DAC write path.
package audiodac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_REL  = 2'd2,
        ST_DONE = 2'd3
    } wr_state_e;

    localparam int AUDIO_WIDTH_DEF = 16;

    // Zero level of an offset-binary sample; the test pattern source starts here.
    localparam logic [AUDIO_WIDTH_DEF-1:0] AUDIO_MIDSCALE = {1'b1, {(AUDIO_WIDTH_DEF-1){1'b0}}};

endpackage

// File: rtl/audiodac_wr_arbiter_rr_pick.sv
// Rotate-priority encoder: lowest set request at or above ptr_i, else lowest set overall.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             vld_o
);

    logic [IDX_W-1:0] idx_hi, idx_lo;
    logic             vld_hi, vld_lo;

    // Scanning downward leaves the lowest matching index in each half.
    always_comb begin
        idx_hi = '0;
        idx_lo = '0;
        vld_hi = 1'b0;
        vld_lo = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_i[k]) begin
                idx_lo = IDX_W'(k);
                vld_lo = 1'b1;
                if (IDX_W'(k) >= ptr_i) begin
                    idx_hi = IDX_W'(k);
                    vld_hi = 1'b1;
                end
            end
        end
    end

    assign idx_o = vld_hi ? idx_hi : idx_lo;
    assign vld_o = vld_lo;

endmodule

// File: rtl/audiodac_wr_arbiter.sv
// Round-robin arbiter sharing the DAC FIFO rdy/ack write port among NREQ producers,
// with optional timeout drop of samples stalled on a full FIFO.
module audiodac_wr_arbiter
    import audiodac_pkg::*;
#(
    parameter int AUDIO_WIDTH = AUDIO_WIDTH_DEF,
    parameter int NREQ        = 2,
    parameter int TMO_W       = 8,
    parameter int CNT_W       = 8
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic [NREQ-1:0]             req_i,
    input  logic [NREQ*AUDIO_WIDTH-1:0] req_data_i,
    output logic [NREQ-1:0]             req_ack_o,
    output logic [NREQ-1:0]             req_drop_o,
    output logic                        fifo_rdy_o,
    output logic [AUDIO_WIDTH-1:0]      fifo_data_o,
    input  logic                        fifo_ack_i,
    input  logic                        fifo_full_i,
    input  logic                        drop_en_i,
    input  logic [TMO_W-1:0]            tmo_i,
    output logic [CNT_W-1:0]            drop_cnt_o,
    input  logic                        drop_clr_i,
    output logic                        busy_o
);

    localparam int IDX_W = (NREQ > 2) ? 2 : 1;

    wr_state_e               state_q;
    logic [IDX_W-1:0]        grant_q, rr_ptr_q, rr_ptr_d;
    logic [TMO_W-1:0]        tmo_cnt_q;
    logic                    drop_q;
    logic [NREQ-1:0]         ack_q, drop_flag_q, grant_oh;
    logic                    rdy_q, busy_q;
    logic [AUDIO_WIDTH-1:0]  data_q, pick_data;
    logic [CNT_W-1:0]        drop_cnt_q;
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_vld;
    logic                    wr_tmo;

    rr_pick #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i (req_i),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

    always_comb begin
        pick_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (pick_idx == IDX_W'(k)) pick_data = req_data_i[k*AUDIO_WIDTH +: AUDIO_WIDTH];
        end
    end

    assign grant_oh = NREQ'(1) << grant_q;
    assign rr_ptr_d = (int'(grant_q) == NREQ - 1) ? '0 : grant_q + 1'b1;

    // An ack from the FIFO always wins over a timeout in the same cycle.
    assign wr_tmo = (state_q == ST_WR) && !fifo_ack_i && fifo_full_i &&
                    (tmo_cnt_q == '0) && drop_en_i && (tmo_i != '0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            tmo_cnt_q   <= '0;
            drop_q      <= 1'b0;
            ack_q       <= '0;
            drop_flag_q <= '0;
            rdy_q       <= 1'b0;
            busy_q      <= 1'b0;
            data_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pick_vld) begin
                        grant_q   <= pick_idx;
                        data_q    <= pick_data;
                        tmo_cnt_q <= tmo_i;
                        rdy_q     <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ST_WR;
                    end
                end
                ST_WR: begin
                    if (fifo_ack_i) begin
                        rdy_q   <= 1'b0;
                        state_q <= ST_REL;
                    end else if (wr_tmo) begin
                        rdy_q       <= 1'b0;
                        drop_q      <= 1'b1;
                        ack_q       <= grant_oh;
                        drop_flag_q <= grant_oh;
                        state_q     <= ST_DONE;
                    end else if (fifo_full_i && tmo_cnt_q != '0) begin
                        tmo_cnt_q <= tmo_cnt_q - 1'b1;
                    end
                end
                ST_REL: begin
                    if (!fifo_ack_i) begin
                        ack_q       <= grant_oh;
                        drop_flag_q <= drop_q ? grant_oh : '0;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // A requester that already let go gets a one-cycle ack.
                    if (!req_i[grant_q]) begin
                        ack_q       <= '0;
                        drop_flag_q <= '0;
                        drop_q      <= 1'b0;
                        rr_ptr_q    <= rr_ptr_d;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            drop_cnt_q <= '0;
        end else if (drop_clr_i) begin
            drop_cnt_q <= '0;
        end else if (wr_tmo && !(&drop_cnt_q)) begin
            drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    assign req_ack_o   = ack_q;
    assign req_drop_o  = drop_flag_q;
    assign fifo_rdy_o  = rdy_q;
    assign fifo_data_o = data_q;
    assign drop_cnt_o  = drop_cnt_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_audiodac_wr_arbiter.sv
// Self-checking bench: transaction-level round-robin model, FIFO responder, directed corner cases.
module tb_audiodac_wr_arbiter;

    localparam int AW    = 16;
    localparam int NREQ  = 2;
    localparam int TMO_W = 8;
    localparam int CNT_W = 8;

    logic                   clk_i = 1'b0;
    logic                   rst_n_i;
    logic [NREQ-1:0]        req_i;
    logic [NREQ*AW-1:0]     req_data_i;
    logic [NREQ-1:0]        req_ack_o, req_drop_o;
    logic                   fifo_rdy_o;
    logic [AW-1:0]          fifo_data_o;
    logic                   fifo_ack_i, fifo_full_i, drop_en_i, drop_clr_i, busy_o;
    logic [TMO_W-1:0]       tmo_i;
    logic [CNT_W-1:0]       drop_cnt_o;

    always #5 clk_i = ~clk_i;

    audiodac_wr_arbiter #(
        .AUDIO_WIDTH (AW),
        .NREQ        (NREQ),
        .TMO_W       (TMO_W),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .req_i       (req_i),
        .req_data_i  (req_data_i),
        .req_ack_o   (req_ack_o),
        .req_drop_o  (req_drop_o),
        .fifo_rdy_o  (fifo_rdy_o),
        .fifo_data_o (fifo_data_o),
        .fifo_ack_i  (fifo_ack_i),
        .fifo_full_i (fifo_full_i),
        .drop_en_i   (drop_en_i),
        .tmo_i       (tmo_i),
        .drop_cnt_o  (drop_cnt_o),
        .drop_clr_i  (drop_clr_i),
        .busy_o      (busy_o)
    );

    int n_chk = 0, n_err = 0, cyc = 0;
    int ack_dly = 0;
    bit lat_rnd = 0, auto_req = 0, alt_mode = 0, exp_drop = 0;
    int p_raise = 0;
    int mptr = 0, exp_g = 0, last_g = -1, alt_bad = 0, n_acks = 0;
    int t_rdy = 0, t_ack = 0, mcnt = 0;
    logic [AW-1:0] exp_data = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: FIFO responder, transaction monitor, then producer behaviour.
    task automatic tick();
        logic            rdy_b;
        logic [NREQ-1:0] req_b, ack_b;
        rdy_b = fifo_rdy_o;
        req_b = req_i;
        ack_b = req_ack_o;
        @(posedge clk_i);
        #1;
        cyc++;
        if (rdy_b && !fifo_ack_i && !fifo_full_i) begin
            if (ack_dly == 0) fifo_ack_i = 1'b1;
            else ack_dly--;
        end else if (!rdy_b && fifo_ack_i) begin
            fifo_ack_i = 1'b0;
            ack_dly = lat_rnd ? int'($urandom_range(0, 2)) : 0;
        end
        if (fifo_rdy_o && !rdy_b) begin
            exp_g = -1;
            for (int i = 0; i < NREQ; i++) begin
                int j;
                j = (mptr + i) % NREQ;
                if (exp_g < 0 && req_b[j]) exp_g = j;
            end
            chk("grant_valid", exp_g >= 0, 1);
            if (exp_g < 0) exp_g = 0;
            exp_data = req_data_i[exp_g*AW +: AW];
            chk("grant_data", fifo_data_o, exp_data);
            t_rdy = cyc;
        end
        if (req_ack_o != '0 && ack_b == '0) begin
            chk("ack_onehot", req_ack_o, 1 << exp_g);
            chk("drop_flag", req_drop_o, exp_drop ? (1 << exp_g) : 0);
            chk("data_hold", fifo_data_o, exp_data);
            if (alt_mode && last_g == exp_g) alt_bad++;
            last_g = exp_g;
            mptr = (exp_g + 1) % NREQ;
            t_ack = cyc;
            n_acks++;
        end
        if (auto_req) begin
            for (int k = 0; k < NREQ; k++) begin
                if (req_i[k] && req_ack_o[k] && (alt_mode || $urandom_range(0, 1) == 0)) begin
                    req_i[k] = 1'b0;
                end else if (!req_i[k] && !req_ack_o[k] && int'($urandom_range(0, 99)) < p_raise) begin
                    req_data_i[k*AW +: AW] = AW'($urandom);
                    req_i[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        while (req_ack_o == '0 && n < 300) begin
            tick();
            n++;
        end
        chk(tag, req_ack_o != '0, 1);
    endtask

    task automatic drop_req(input int k);
        int n = 0;
        req_i[k] = 1'b0;
        while (req_ack_o[k] && n < 20) begin
            tick();
            n++;
        end
        chk("ack_release", req_ack_o[k], 0);
    endtask

    task automatic drain();
        int n = 0;
        auto_req = 0;
        req_i = '0;
        while ((busy_o || req_ack_o != '0) && n < 100) begin
            tick();
            n++;
        end
        chk("drain_idle", busy_o, 0);
    endtask

    initial begin
        int t0;
        int bad;
        rst_n_i = 1'b0;
        req_i = '0;
        req_data_i = '0;
        fifo_ack_i = 1'b0;
        fifo_full_i = 1'b0;
        drop_en_i = 1'b0;
        drop_clr_i = 1'b0;
        tmo_i = '0;
        #23;
        chk("rst_rdy", fifo_rdy_o, 0);
        chk("rst_ack", req_ack_o, 0);
        chk("rst_drop", req_drop_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_cnt", drop_cnt_o, 0);
        chk("rst_data", fifo_data_o, 0);
        rst_n_i = 1'b1;
        tick();

        // Single request
        req_data_i[0 +: AW] = 16'h1234;
        req_i = 2'b01;
        t0 = cyc;
        tick();
        chk("t1_rdy", fifo_rdy_o, 1);
        chk("t1_data", fifo_data_o, 16'h1234);
        chk("t1_rdy_lat", t_rdy - t0, 1);
        wait_ack("t1_ack_seen");
        chk("t1_ack_lat", t_ack - t_rdy, 4);
        chk("t1_ack", req_ack_o, 2'b01);
        chk("t1_rdy_low", fifo_rdy_o, 0);
        drop_req(0);
        chk("t1_idle", busy_o, 0);

        // Contention: both always requesting
        auto_req = 1; alt_mode = 1; p_raise = 100; alt_bad = 0; last_g = -1;
        t0 = n_acks;
        for (int n = 0; n < 300 && n_acks - t0 < 8; n++) tick();
        chk("cont_count", n_acks - t0 >= 8, 1);
        chk("cont_alternate", alt_bad, 0);
        drain();
        alt_mode = 0;

        // Randomized traffic with variable FIFO ack latency
        auto_req = 1; p_raise = 30; lat_rnd = 1;
        repeat (1500) tick();
        drain();
        lat_rnd = 0;

        // Full FIFO, drop disabled
        fifo_full_i = 1'b1; drop_en_i = 1'b0; tmo_i = 8'd5;
        req_data_i[AW +: AW] = 16'hBEEF;
        req_i = 2'b10;
        tick();
        bad = 0;
        repeat (50) begin
            if (!fifo_rdy_o || req_ack_o != '0 || drop_cnt_o != '0) bad++;
            tick();
        end
        chk("full_hold", bad, 0);
        fifo_full_i = 1'b0;
        wait_ack("full_ack_seen");
        chk("full_cnt", drop_cnt_o, 0);
        drop_req(1);

        // Timeout drop
        fifo_full_i = 1'b1; drop_en_i = 1'b1; tmo_i = 8'd5; exp_drop = 1;
        req_data_i[0 +: AW] = 16'h0F0F;
        req_i = 2'b01;
        tick();
        wait_ack("tmo_ack_seen");
        chk("tmo_lat", t_ack - t_rdy, 6);
        chk("tmo_drop", req_drop_o, 2'b01);
        chk("tmo_cnt1", drop_cnt_o, 1);
        mcnt = 1;
        drop_req(0);
        tmo_i = 8'd1;
        repeat (300) begin
            req_i = 2'b01;
            tick();
            wait_ack("sat_ack_seen");
            mcnt = (mcnt < 255) ? mcnt + 1 : 255;
            drop_req(0);
        end
        chk("drop_sat", drop_cnt_o, mcnt);
        drop_clr_i = 1'b1;
        tick();
        drop_clr_i = 1'b0;
        chk("drop_clr", drop_cnt_o, 0);
        // Clear in the same cycle as a drop increment
        req_i = 2'b01;
        tick();
        tick();
        drop_clr_i = 1'b1;
        tick();
        drop_clr_i = 1'b0;
        chk("clr_pri_ack", req_ack_o, 2'b01);
        chk("clr_pri_cnt", drop_cnt_o, 0);
        drop_req(0);
        req_i = 2'b01;
        tick();
        wait_ack("cnt1_ack_seen");
        drop_req(0);
        chk("cnt_after", drop_cnt_o, 1);
        exp_drop = 0;

        // Early release while in WR
        fifo_full_i = 1'b0; drop_en_i = 1'b0;
        req_i = 2'b01;
        tick();
        chk("er_wr", fifo_rdy_o, 1);
        req_i[0] = 1'b0;
        wait_ack("er_ack_seen");
        tick();
        chk("er_pulse", req_ack_o, 0);
        chk("er_idle", busy_o, 0);

        // Reset in the middle of WR (last grant was 0, so pointer sits at 1)
        fifo_full_i = 1'b1;
        req_i = 2'b10;
        tick();
        chk("mr_wr", fifo_rdy_o, 1);
        #2 rst_n_i = 1'b0;
        #1;
        chk("mr_rdy", fifo_rdy_o, 0);
        chk("mr_busy", busy_o, 0);
        chk("mr_cnt", drop_cnt_o, 0);
        chk("mr_ack", req_ack_o, 0);
        mptr = 0;
        req_i = '0;
        fifo_full_i = 1'b0;
        fifo_ack_i = 1'b0;
        @(posedge clk_i);
        #1 rst_n_i = 1'b1;
        req_data_i = {16'h5A5A, 16'hA5A5};
        req_i = 2'b11;
        tick();
        chk("mr_ptr", fifo_data_o, 16'hA5A5);
        wait_ack("mr_ack_seen");
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
